// File: rtl/pin_drive_arb_pkg.sv
// Shared types for the pin-bank drive arbiter: FSM state encoding and the
// captured request payload.
package pin_drive_arb_pkg;

    localparam int unsigned PDA_WIDTH = 8;
    localparam int unsigned PDA_DUR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PDA_WIDTH-1:0] val;
        logic [PDA_WIDTH-1:0] oe;
        logic [PDA_DUR_W-1:0] dur;
    } payload_t;

endpackage

// File: rtl/pin_drive_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, returned as a one-hot grant plus its index.
module pin_drive_rr_arb #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NumReq);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/pin_drive_arb.sv
// Time-shares one bidirectional pin bank between requesters with timed drive
// windows, a one-cycle all-released turnaround, and idle pull control.
//
// state    | meaning
// ST_IDLE  | bank released; grant the round-robin winner this cycle
// ST_DRIVE | owner's value/oe on the pins for dur cycles
// ST_TURN  | one cycle with all outputs off; done pulse to the owner
module pin_drive_arb
    import pin_drive_arb_pkg::*;
#(
    parameter  int unsigned Width  = PDA_WIDTH,
    parameter  int unsigned NumReq = 2,
    parameter  int unsigned DurW   = PDA_DUR_W,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_i,
    input  logic [NumReq*Width-1:0] req_val_i,
    input  logic [NumReq*Width-1:0] req_oe_i,
    input  logic [NumReq*DurW-1:0] req_dur_i,
    output logic [NumReq-1:0]      gnt_o,
    output logic [NumReq-1:0]      done_o,
    input  logic [Width-1:0]       cfg_pu_i,
    input  logic [Width-1:0]       cfg_pd_i,
    input  logic [Width-1:0]       pins_i,
    output logic [Width-1:0]       pins_o,
    output logic [Width-1:0]       pins_oe_o,
    output logic [Width-1:0]       pins_pu_o,
    output logic [Width-1:0]       pins_pd_o,
    output logic [Width-1:0]       sample_o,
    output logic                   busy_o,
    output logic [IdxW-1:0]        owner_o
);

    state_e            state_q;
    logic [DurW-1:0]   cnt_q;
    logic [Width-1:0]  pins_q, oe_q, oe_d, pu_q, pd_q, sample_q;
    logic [IdxW-1:0]   owner_q, ptr_q, ptr_d;
    logic [IdxW-1:0]   arb_idx;
    logic [NumReq-1:0] arb_gnt;
    logic              arb_valid;
    logic              take;
    payload_t          sel;

    pin_drive_rr_arb #(
        .NumReq(NumReq),
        .IdxW  (IdxW)
    ) u_rr (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    always_comb begin
        sel.val = req_val_i[32'(arb_idx)*Width +: Width];
        sel.oe  = req_oe_i[32'(arb_idx)*Width +: Width];
        sel.dur = req_dur_i[32'(arb_idx)*DurW +: DurW];
        // No grant while reset is asserted: the edge would not capture it.
        take    = rst_ni && (state_q == ST_IDLE) && arb_valid;
        ptr_d   = (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
    end

    // Next output-enable drives the pull registers so pulls never overlap a drive.
    always_comb begin
        oe_d = '0;
        if (take && (sel.dur != '0)) begin
            oe_d = sel.oe;
        end else if ((state_q == ST_DRIVE) && (cnt_q != DurW'(1))) begin
            oe_d = oe_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pins_q   <= '0;
            oe_q     <= '0;
            pu_q     <= '0;
            pd_q     <= '0;
            sample_q <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
        end else begin
            oe_q <= oe_d;
            pu_q <= cfg_pu_i & ~oe_d;
            pd_q <= cfg_pd_i & ~cfg_pu_i & ~oe_d;
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        owner_q <= arb_idx;
                        ptr_q   <= ptr_d;
                        cnt_q   <= sel.dur;
                        if (sel.dur != '0) begin
                            pins_q  <= sel.val;
                            state_q <= ST_DRIVE;
                        end else begin
                            state_q <= ST_TURN;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DurW'(1)) begin
                        sample_q <= pins_i;
                        pins_q   <= '0;
                        state_q  <= ST_TURN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_TURN: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_o  = take ? arb_gnt : '0;
        done_o = '0;
        if (state_q == ST_TURN) begin
            done_o[owner_q] = 1'b1;
        end
    end

    assign pins_o    = pins_q;
    assign pins_oe_o = oe_q;
    assign pins_pu_o = pu_q;
    assign pins_pd_o = pd_q;
    assign sample_o  = sample_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_pin_drive_arb.sv
// Scoreboard bench for pin_drive_arb: a window-schedule reference model
// predicts grants/dones and per-cycle pin state; a monitor pops events.
module tb_pin_drive_arb;

    localparam int W  = 8;
    localparam int NR = 2;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [NR-1:0]  req_i = '0;
    logic [NR*W-1:0]  req_val_i = '0;
    logic [NR*W-1:0]  req_oe_i = '0;
    logic [NR*DW-1:0] req_dur_i = '0;
    logic [NR-1:0]  gnt_o, done_o;
    logic [W-1:0]   cfg_pu_i = '0, cfg_pd_i = '0, pins_i = '0;
    logic [W-1:0]   pins_o, pins_oe_o, pins_pu_o, pins_pd_o, sample_o;
    logic           busy_o;
    logic [0:0]     owner_o;

    pin_drive_arb #(.Width(W), .NumReq(NR), .DurW(DW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .req_val_i(req_val_i),
        .req_oe_i (req_oe_i),
        .req_dur_i(req_dur_i),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .cfg_pu_i (cfg_pu_i),
        .cfg_pd_i (cfg_pd_i),
        .pins_i   (pins_i),
        .pins_o   (pins_o),
        .pins_oe_o(pins_oe_o),
        .pins_pu_o(pins_pu_o),
        .pins_pd_o(pins_pd_o),
        .sample_o (sample_o),
        .busy_o   (busy_o),
        .owner_o  (owner_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit is_done;
        int idx;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each grant books a schedule (drive cycles, turn cycle,
    // next free cycle); expectations for every cycle are read off that schedule.
    int busy_until = 0, rr = 0, w_start = -1, w_end = -1, e_owner = 0;
    logic [W-1:0] w_val = '0, w_oe = '0, e_sample = '0, e_pu = '0, e_pd = '0;

    always @(negedge clk) begin : model_b
        int win, d;
        bit drv, nx_drv;
        logic [W-1:0] nx_oe;
        cyc++;
        drv = (cyc >= w_start) && (cyc <= w_end);
        chk("pins_oe", 32'(pins_oe_o), 32'(drv ? w_oe : 8'h00));
        chk("pins", 32'(pins_o), 32'(drv ? w_val : 8'h00));
        chk("pull_up", 32'(pins_pu_o), 32'(e_pu));
        chk("pull_down", 32'(pins_pd_o), 32'(e_pd));
        chk("sample", 32'(sample_o), 32'(e_sample));
        chk("busy", 32'(busy_o), 32'(cyc < busy_until));
        chk("owner", 32'(owner_o), 32'(e_owner));
        if (rst_ni && (w_end >= w_start) && (cyc == w_end)) e_sample = pins_i;
        if (rst_ni && (cyc >= busy_until) && (req_i != '0)) begin
            win = -1;
            for (int k = 0; k < NR; k++)
                if (win < 0 && req_i[(rr + k) % NR]) win = (rr + k) % NR;
            d = int'(req_dur_i[win*DW +: DW]);
            exp_q.push_back('{cyc: cyc, is_done: 1'b0, idx: win});
            exp_q.push_back('{cyc: cyc + d + 1, is_done: 1'b1, idx: win});
            w_start = cyc + 1;
            w_end = cyc + d;
            w_val = req_val_i[win*W +: W];
            w_oe = req_oe_i[win*W +: W];
            busy_until = cyc + d + 2;
            rr = (win + 1) % NR;
            e_owner = win;
        end
        nx_drv = (cyc + 1 >= w_start) && (cyc + 1 <= w_end);
        nx_oe = nx_drv ? w_oe : 8'h00;
        if (!rst_ni) begin
            e_sample = '0; e_pu = '0; e_pd = '0;
            rr = 0; e_owner = 0; w_start = -1; w_end = -1;
            busy_until = cyc + 1;
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        end else begin
            e_pu = cfg_pu_i & ~nx_oe;
            e_pd = cfg_pd_i & ~cfg_pu_i & ~nx_oe;
        end
    end

    task automatic take_ev(input bit is_done, input logic [NR-1:0] vec);
        ev_t e;
        logic [NR-1:0] ev;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].is_done != is_done) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s cyc=%0d actual=%b required=none", is_done ? "done" : "gnt", cyc, vec);
        end else begin
            e = exp_q.pop_front();
            ev = '0;
            ev[e.idx] = 1'b1;
            chk(is_done ? "done_vec" : "gnt_vec", 32'(vec), 32'(ev));
        end
    endtask

    always @(negedge clk) begin : mon_b
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_%s cyc=%0d actual=absent required=idx%0d", exp_q[0].is_done ? "done" : "gnt", exp_q[0].cyc, exp_q[0].idx);
            void'(exp_q.pop_front());
        end
        if (gnt_o != '0) take_ev(1'b0, gnt_o);
        if (done_o != '0) take_ev(1'b1, done_o);
    end

    logic [NR-1:0] seen = '0;

    task automatic tick();
        @(negedge clk);
        #2;
        seen = gnt_o;
        @(posedge clk);
        #1;
        pins_i = 8'($urandom);
    endtask

    task automatic set_req(input int r, input logic [7:0] v, input logic [7:0] o, input logic [7:0] d);
        req_val_i[r*W +: W] = v;
        req_oe_i[r*W +: W] = o;
        req_dur_i[r*DW +: DW] = d;
        req_i[r] = 1'b1;
    endtask

    task automatic wait_gnt(input int r, input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (seen[r]) begin
                req_i[r] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout req=%0d actual=none required=grant", r);
        req_i[r] = 1'b0;
    endtask

    task automatic rand_payload(input int r);
        set_req(r, 8'($urandom), 8'($urandom),
                ($urandom_range(9) == 0) ? 8'd20 : 8'($urandom_range(5)));
    endtask

    initial begin
        cfg_pu_i = 8'h0F;
        cfg_pd_i = 8'hF0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        cfg_pu_i = 8'h33;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        cfg_pu_i = 8'h0F;
        repeat (2) tick();

        set_req(0, 8'hA5, 8'hFF, 8'd3);
        wait_gnt(0, 5);
        repeat (6) tick();

        set_req(0, 8'h11, 8'hFF, 8'd2);
        set_req(1, 8'h22, 8'hF0, 8'd2);
        repeat (20) tick();
        req_i = '0;
        repeat (5) tick();

        cfg_pu_i = 8'hFF;
        cfg_pd_i = 8'h00;
        set_req(0, 8'hC3, 8'h0F, 8'd4);
        wait_gnt(0, 5);
        repeat (7) tick();

        set_req(1, 8'hFF, 8'hFF, 8'd0);
        wait_gnt(1, 5);
        repeat (3) tick();

        set_req(0, 8'h5A, 8'hFF, 8'd5);
        wait_gnt(0, 5);
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        set_req(1, 8'h3C, 8'hAA, 8'd2);
        wait_gnt(1, 5);
        repeat (5) tick();

        for (int i = 0; i < 400; i++) begin
            tick();
            for (int r = 0; r < NR; r++) begin
                if (seen[r]) begin
                    if ($urandom_range(1) == 0) req_i[r] = 1'b0;
                    else rand_payload(r);
                end else if (!req_i[r] && $urandom_range(2) == 0) begin
                    rand_payload(r);
                end else if (req_i[r] && $urandom_range(15) == 0) begin
                    req_i[r] = 1'b0;
                end
            end
            if ($urandom_range(7) == 0) begin
                cfg_pu_i = 8'($urandom);
                cfg_pd_i = 8'($urandom);
            end
            rst_ni = ($urandom_range(99) != 0);
        end

        rst_ni = 1'b1;
        req_i = '0;
        repeat (30) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
